// File: rtl/bus_ram_responder.sv
// bus_ram_responder
// -----------------
// Word-organised on-chip RAM that answers the CPU bus request/ready
// protocol. A request is accepted in IDLE and then held for LATENCY wait
// cycles. The access is then committed, and a one-cycle ready pulse
// follows. The responder then waits for the initiator to drop request
// before it accepts the next request.
//
// Parameters
//   SIZE     log2 of the RAM depth in 32-bit words (at most 29)
//   LATENCY  wait cycles between acceptance and commit, 0..15
//   BASE     byte address of word 0, aligned to 4*2^SIZE
//
// Ports
//   i_clock        in   1   rising-edge clock
//   i_reset        in   1   asynchronous active-high reset
//   i_bus_rw       in   1   1 = write, 0 = read
//   i_bus_request  in   1   held high by the initiator until ready
//   o_bus_ready    out  1   single-cycle completion pulse
//   i_bus_address  in   32  byte address, bits [1:0] ignored
//   o_bus_rdata    out  32  registered read data
//   i_bus_wdata    in   32  write data
//   i_bus_wmask    in   4   byte-lane enables
//   o_fault        out  1   sticky out-of-range flag
//
// Optional feature
//   BUS_RAM_RANGE_CHECK_EN  When this macro is defined, an access outside
//   [BASE, BASE+4*2^SIZE) still completes normally, but it writes nothing,
//   returns 32'hDEAD_BEEF and sets o_fault until reset. When the macro is
//   not defined, addresses wrap modulo the RAM size and o_fault is 0.

module bus_ram_responder #(
    parameter int          SIZE    = 12,
    parameter int          LATENCY = 1,
    parameter logic [31:0] BASE    = 32'h0000_0000
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_bus_rw,
    input  logic        i_bus_request,
    output logic        o_bus_ready,
    input  logic [31:0] i_bus_address,
    output logic [31:0] o_bus_rdata,
    input  logic [31:0] i_bus_wdata,
    input  logic [3:0]  i_bus_wmask,
    output logic        o_fault
);

    localparam int DEPTH = 1 << SIZE;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DONE,
        ST_RELEASE
    } state_t;

    state_t            state;
    logic [3:0]        wait_count;
    logic              rw_q;
    logic [SIZE-1:0]   index_q;
    logic [31:0]       wdata_q;
    logic [3:0]        wmask_q;
    logic [31:0]       mem [DEPTH];

    logic [31:0]       offset;
    logic [SIZE-1:0]   index_in;
    logic              commit;
    logic              do_write;

    assign offset   = i_bus_address - BASE;
    assign index_in = offset[SIZE+1:2];

    // The access happens on the WAIT edge that still sees request high
    // after the counter has run out.
    assign commit = (state == ST_WAIT) && i_bus_request && (wait_count == 4'd0);

`ifdef BUS_RAM_RANGE_CHECK_EN
    logic in_range_in;
    logic in_range_q;
    logic fault_q;
    logic unused_addr_bits;

    // Any offset bit above the word index means the address lies outside the RAM.
    assign in_range_in      = (offset >> (SIZE + 2)) == 32'd0;
    assign do_write         = commit && rw_q && in_range_q;
    assign o_fault          = fault_q;
    assign unused_addr_bits = ^offset[1:0];
`else
    logic unused_addr_bits;

    assign do_write         = commit && rw_q;
    assign o_fault          = 1'b0;
    assign unused_addr_bits = ^{offset[31:SIZE+2], offset[1:0]};
`endif

    // Control FSM with registered ready/rdata. Inputs are captured only in
    // IDLE, so that bus changes during WAIT and RELEASE have no effect.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state       <= ST_IDLE;
            wait_count  <= 4'd0;
            rw_q        <= 1'b0;
            index_q     <= '0;
            wdata_q     <= 32'd0;
            wmask_q     <= 4'd0;
            o_bus_ready <= 1'b0;
            o_bus_rdata <= 32'd0;
`ifdef BUS_RAM_RANGE_CHECK_EN
            in_range_q  <= 1'b0;
            fault_q     <= 1'b0;
`endif
        end else begin
            o_bus_ready <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_bus_request) begin
                        rw_q       <= i_bus_rw;
                        index_q    <= index_in;
                        wdata_q    <= i_bus_wdata;
                        wmask_q    <= i_bus_wmask;
                        wait_count <= 4'(LATENCY);
`ifdef BUS_RAM_RANGE_CHECK_EN
                        in_range_q <= in_range_in;
`endif
                        state      <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (!i_bus_request) begin
                        state <= ST_IDLE;
                    end else if (wait_count == 4'd0) begin
                        state       <= ST_DONE;
                        o_bus_ready <= 1'b1;
`ifdef BUS_RAM_RANGE_CHECK_EN
                        if (!in_range_q) begin
                            o_bus_rdata <= 32'hDEAD_BEEF;
                            fault_q     <= 1'b1;
                        end else if (!rw_q) begin
                            o_bus_rdata <= mem[index_q];
                        end
`else
                        if (!rw_q) begin
                            o_bus_rdata <= mem[index_q];
                        end
`endif
                    end else begin
                        wait_count <= wait_count - 4'd1;
                    end
                end
                ST_DONE: begin
                    state <= ST_RELEASE;
                end
                ST_RELEASE: begin
                    if (!i_bus_request) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // The RAM array has no reset, so that it maps onto block RAM. Only the
    // byte lanes that are enabled are written.
    always_ff @(posedge i_clock) begin
        if (do_write) begin
            for (int lane = 0; lane < 4; lane++) begin
                if (wmask_q[lane]) begin
                    mem[index_q][8*lane +: 8] <= wdata_q[8*lane +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_bus_ram_responder.sv
// tb_bus_ram_responder
// --------------------
// Directed bench for bus_ram_responder. Three instances share one bus and
// use LATENCY 1, 0 and 15. Each access pushes its expected rdata, ready
// latency and fault state into a queue. When the DUT responds, the entry is
// popped and compared. Expected values come from a per-instance memory model.

module tb_bus_ram_responder;

    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam int          SIZE  = 4;
    localparam int          DEPTH = 16;
    localparam int          NDUT  = 3;
    localparam int          MAX_WAIT = 40;

    typedef struct {
        logic [31:0] rdata;
        int          latency;
        logic        fault;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        bus_rw;
    logic [31:0] bus_address;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wmask;
    logic        request [NDUT];
    logic        ready   [NDUT];
    logic [31:0] rdata   [NDUT];
    logic        fault   [NDUT];

    int          errors = 0;
    int          checks = 0;
    int          latencies [NDUT] = '{1, 0, 15};
    logic [31:0] model_mem  [NDUT][DEPTH];
    logic [31:0] last_rdata [NDUT];
    logic        exp_fault  [NDUT];
    exp_t        exp_queue [$];

    always #5 clock = ~clock;

    bus_ram_responder #(.SIZE(SIZE), .LATENCY(1), .BASE(BASE)) u_dut_lat1 (
        .i_clock(clock), .i_reset(reset), .i_bus_rw(bus_rw), .i_bus_request(request[0]),
        .o_bus_ready(ready[0]), .i_bus_address(bus_address), .o_bus_rdata(rdata[0]),
        .i_bus_wdata(bus_wdata), .i_bus_wmask(bus_wmask), .o_fault(fault[0])
    );

    bus_ram_responder #(.SIZE(SIZE), .LATENCY(0), .BASE(BASE)) u_dut_lat0 (
        .i_clock(clock), .i_reset(reset), .i_bus_rw(bus_rw), .i_bus_request(request[1]),
        .o_bus_ready(ready[1]), .i_bus_address(bus_address), .o_bus_rdata(rdata[1]),
        .i_bus_wdata(bus_wdata), .i_bus_wmask(bus_wmask), .o_fault(fault[1])
    );

    bus_ram_responder #(.SIZE(SIZE), .LATENCY(15), .BASE(BASE)) u_dut_lat15 (
        .i_clock(clock), .i_reset(reset), .i_bus_rw(bus_rw), .i_bus_request(request[2]),
        .o_bus_ready(ready[2]), .i_bus_address(bus_address), .o_bus_rdata(rdata[2]),
        .i_bus_wdata(bus_wdata), .i_bus_wmask(bus_wmask), .o_fault(fault[2])
    );

    // Single comparison point: counts every check and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Updates the model and queues the expected response. It then runs one
    // full bus transaction on instance d and keeps request high for `hold`
    // cycles after ready, scrambling the bus inputs meanwhile.
    task automatic applyStimulus(input int d, input logic rw, input logic [31:0] addr,
                                 input logic [31:0] wd, input logic [3:0] mask,
                                 input int hold, input string tag);
        logic [31:0] off;
        int          idx;
        bit          use_ram;
        int          cycles;
        bit          got;
        int          extra;
        exp_t        e;

        off     = addr - BASE;
        idx     = int'(off[SIZE+1:2]);
        use_ram = 1'b1;
`ifdef BUS_RAM_RANGE_CHECK_EN
        if (off >= 32'(4 * DEPTH)) begin
            use_ram       = 1'b0;
            last_rdata[d] = 32'hDEAD_BEEF;
            exp_fault[d]  = 1'b1;
        end
`endif
        if (use_ram) begin
            if (rw) begin
                for (int n = 0; n < 4; n++) begin
                    if (mask[n]) model_mem[d][idx][8*n +: 8] = wd[8*n +: 8];
                end
            end else begin
                last_rdata[d] = model_mem[d][idx];
            end
        end
        exp_queue.push_back('{rdata: last_rdata[d], latency: latencies[d] + 2,
                              fault: exp_fault[d]});

        bus_rw      = rw;
        bus_address = addr;
        bus_wdata   = wd;
        bus_wmask   = mask;
        request[d]  = 1'b1;
        cycles      = 0;
        got         = 1'b0;
        while (cycles < MAX_WAIT && !got) begin
            @(posedge clock); #1;
            cycles++;
            if (ready[d]) got = 1'b1;
        end

        e = exp_queue.pop_front();
        checkOutput({tag, "_ready_seen"}, 32'(got), 32'd1);
        checkOutput({tag, "_latency"}, 32'(cycles), 32'(e.latency));
        checkOutput({tag, "_rdata"}, rdata[d], e.rdata);
        checkOutput({tag, "_fault"}, 32'(fault[d]), 32'(e.fault));

        bus_rw      = ~rw;
        bus_address = ~addr;
        bus_wdata   = ~wd;
        bus_wmask   = ~mask;
        extra       = 0;
        for (int i = 0; i < hold; i++) begin
            @(posedge clock); #1;
            if (ready[d]) extra++;
        end
        checkOutput({tag, "_extra_ready"}, 32'(extra), 32'd0);
        checkOutput({tag, "_rdata_stable"}, rdata[d], e.rdata);

        request[d] = 1'b0;
        @(posedge clock); #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int extra;

        reset       = 1'b1;
        bus_rw      = 1'b0;
        bus_address = 32'd0;
        bus_wdata   = 32'd0;
        bus_wmask   = 4'd0;
        for (int d = 0; d < NDUT; d++) begin
            request[d]    = 1'b0;
            last_rdata[d] = 32'd0;
            exp_fault[d]  = 1'b0;
        end
        #23;
        for (int d = 0; d < NDUT; d++) begin
            checkOutput($sformatf("reset_ready%0d", d), 32'(ready[d]), 32'd0);
            checkOutput($sformatf("reset_rdata%0d", d), rdata[d], 32'd0);
            checkOutput($sformatf("reset_fault%0d", d), 32'(fault[d]), 32'd0);
        end
        reset = 1'b0;
        @(posedge clock); #1;

        $display("[TB] basic write/read with LATENCY=1");
        applyStimulus(0, 1'b1, BASE + 32'h10, 32'h1234_5678, 4'b1111, 1, "wr_full");
        applyStimulus(0, 1'b0, BASE + 32'h10, 32'h0, 4'b0000, 1, "rd_full");

        $display("[TB] byte-lane masking");
        applyStimulus(0, 1'b1, BASE + 32'h20, 32'hAABB_CCDD, 4'b1111, 1, "wr_preload");
        applyStimulus(0, 1'b1, BASE + 32'h20, 32'h0000_0011, 4'b0001, 1, "wr_lane0");
        applyStimulus(0, 1'b0, BASE + 32'h20, 32'h0, 4'b0000, 1, "rd_lane0");
        applyStimulus(0, 1'b1, BASE + 32'h20, 32'hFFFF_FFFF, 4'b0000, 1, "wr_nomask");
        applyStimulus(0, 1'b0, BASE + 32'h20, 32'h0, 4'b0000, 1, "rd_nomask");
        applyStimulus(0, 1'b1, BASE + 32'h24, 32'h5566_7788, 4'b1010, 1, "wr_lanes31");
        applyStimulus(0, 1'b1, BASE + 32'h24, 32'h0000_0000, 4'b0101, 1, "wr_lanes20");
        applyStimulus(0, 1'b0, BASE + 32'h24, 32'h0, 4'b0000, 1, "rd_lanes");
        applyStimulus(0, 1'b1, BASE + 32'h00, 32'hCAFE_F00D, 4'b1111, 1, "wr_word0");

        $display("[TB] request held after ready, then re-raised");
        applyStimulus(0, 1'b0, BASE + 32'h10, 32'h0, 4'b0000, 5, "rd_hold5");
        applyStimulus(0, 1'b0, BASE + 32'h00, 32'h0, 4'b0000, 1, "rd_after_hold");

        $display("[TB] LATENCY=0 and LATENCY=15");
        applyStimulus(1, 1'b1, BASE + 32'h04, 32'h0BAD_CAFE, 4'b1111, 1, "lat0_wr");
        applyStimulus(1, 1'b0, BASE + 32'h04, 32'h0, 4'b0000, 2, "lat0_rd");
        applyStimulus(2, 1'b1, BASE + 32'h08, 32'h55AA_55AA, 4'b1111, 1, "lat15_wr");
        applyStimulus(2, 1'b0, BASE + 32'h08, 32'h0, 4'b0000, 2, "lat15_rd");

        $display("[TB] write aborted during WAIT");
        bus_rw      = 1'b1;
        bus_address = BASE + 32'h10;
        bus_wdata   = 32'h9999_9999;
        bus_wmask   = 4'b1111;
        request[0]  = 1'b1;
        @(posedge clock); #1;
        request[0]  = 1'b0;
        extra       = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clock); #1;
            if (ready[0]) extra++;
        end
        checkOutput("abort_no_ready", 32'(extra), 32'd0);
        applyStimulus(0, 1'b0, BASE + 32'h10, 32'h0, 4'b0000, 1, "rd_after_abort");

        $display("[TB] address one past the end of the RAM");
        applyStimulus(0, 1'b0, BASE + 32'(4 * DEPTH), 32'h0, 4'b0000, 1, "rd_past_end");
        applyStimulus(0, 1'b0, BASE + 32'h10, 32'h0, 4'b0000, 1, "rd_after_range");

        $display("[TB] reset asserted during WAIT");
        bus_rw      = 1'b1;
        bus_address = BASE + 32'h08;
        bus_wdata   = 32'h1111_1111;
        bus_wmask   = 4'b1111;
        request[2]  = 1'b1;
        repeat (3) begin
            @(posedge clock); #1;
        end
        #2 reset = 1'b1;
        #1;
        checkOutput("async_reset_ready", 32'(ready[2]), 32'd0);
        checkOutput("async_reset_rdata2", rdata[2], 32'd0);
        checkOutput("async_reset_rdata0", rdata[0], 32'd0);
        checkOutput("async_reset_fault0", 32'(fault[0]), 32'd0);
        for (int d = 0; d < NDUT; d++) begin
            last_rdata[d] = 32'd0;
            exp_fault[d]  = 1'b0;
        end
        request[2] = 1'b0;
        #2 reset = 1'b0;
        @(posedge clock); #1;
        applyStimulus(2, 1'b0, BASE + 32'h08, 32'h0, 4'b0000, 1, "rd_after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
